// File: rtl/decode_stage_reg.sv
// -----------------------------------------------------------------------------
// decode_stage_reg
//   Y86-64 decode stage: instruction field decode, register file, six-level
//   operand forwarding, load/use interlock and the D->E pipeline register.
//
//   Optional feature: define DECODE_PERF_CNT_EN to build the saturating stall
//   and bubble performance counters; otherwise both counter ports read 0.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), async active-high reset
//   D_*_i                        instruction held in the D stage
//   e_/M_/W_ dst/val inputs      forwarding sources; W ports also write the file
//   E_icode_i, E_dstM_i          instruction currently in E (load/use check)
//   E_stall_i, E_bubble_i        hold E / inject a bubble into E
//   d_load_use_o                 combinational load/use hazard flag
//   E_*_o                        registered D->E pipeline outputs
//   perf_stall_cnt_o, perf_bubble_cnt_o   performance counters
// -----------------------------------------------------------------------------
module decode_stage_reg #(
    parameter int DW    = 64,
    parameter int NREG  = 15,
    parameter int SP_ID = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          D_valid_i,
    input  logic [3:0]    D_icode_i,
    input  logic [3:0]    D_rA_i,
    input  logic [3:0]    D_rB_i,
    input  logic [DW-1:0] D_valC_i,
    input  logic [DW-1:0] D_valP_i,
    input  logic [3:0]    e_dstE_i,
    input  logic [DW-1:0] e_valE_i,
    input  logic [3:0]    M_dstM_i,
    input  logic [DW-1:0] m_valM_i,
    input  logic [3:0]    M_dstE_i,
    input  logic [DW-1:0] M_valE_i,
    input  logic [3:0]    W_dstM_i,
    input  logic [DW-1:0] W_valM_i,
    input  logic [3:0]    W_dstE_i,
    input  logic [DW-1:0] W_valE_i,
    input  logic [3:0]    E_icode_i,
    input  logic [3:0]    E_dstM_i,
    input  logic          E_stall_i,
    input  logic          E_bubble_i,
    output logic          d_load_use_o,
    output logic          E_valid_o,
    output logic [3:0]    E_icode_o,
    output logic [DW-1:0] E_valA_o,
    output logic [DW-1:0] E_valB_o,
    output logic [DW-1:0] E_valC_o,
    output logic [3:0]    E_dstE_o,
    output logic [3:0]    E_dstM_o,
    output logic [3:0]    E_srcA_o,
    output logic [3:0]    E_srcB_o,
    output logic [31:0]   perf_stall_cnt_o,
    output logic [31:0]   perf_bubble_cnt_o
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [3:0] R_SP     = 4'(SP_ID);
    localparam logic [4:0] NREG_W   = 5'(NREG);

    // ---------------------------------------------------------------- decode
    logic [3:0] src_a, src_b, dst_e, dst_m;

    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (D_icode_i)
            I_CMOVXX, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = D_rA_i;
            I_POPQ, I_RET:                      src_a = R_SP;
            default:                            src_a = R_NONE;
        endcase
        case (D_icode_i)
            I_OPQ, I_RMMOVQ, I_MRMOVQ:           src_b = D_rB_i;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:      src_b = R_SP;
            default:                             src_b = R_NONE;
        endcase
        case (D_icode_i)
            I_CMOVXX, I_IRMOVQ, I_OPQ:           dst_e = D_rB_i;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:      dst_e = R_SP;
            default:                             dst_e = R_NONE;
        endcase
        case (D_icode_i)
            I_MRMOVQ, I_POPQ:                    dst_m = D_rA_i;
            default:                             dst_m = R_NONE;
        endcase
    end

    // --------------------------------------------------------- register file
    // Asynchronous read; a same-cycle W write is picked up through the W
    // forwarding paths rather than by a write-through here.
    logic [DW-1:0] rf_reg [NREG];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // valM takes precedence when both writebacks target one register
                if (W_dstM_i == 4'(i)) begin
                    rf_reg[i] <= W_valM_i;
                end else if (W_dstE_i == 4'(i)) begin
                    rf_reg[i] <= W_valE_i;
                end
            end
        end
    end

    logic [DW-1:0] rf_a, rf_b;

    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if ({1'b0, src_a} < NREG_W) rf_a = rf_reg[src_a];
        if ({1'b0, src_b} < NREG_W) rf_b = rf_reg[src_b];
    end

    // ------------------------------------------------------------ forwarding
    // Youngest producer wins. A source of "none" never matches because
    // src == F is filtered out before any comparison.
    function automatic logic [DW-1:0] fwd(input logic [3:0] src, input logic [DW-1:0] rf_val);
        logic [DW-1:0] v;
        if (src == R_NONE)          v = '0;
        else if (e_dstE_i == src)   v = e_valE_i;
        else if (M_dstM_i == src)   v = m_valM_i;
        else if (M_dstE_i == src)   v = M_valE_i;
        else if (W_dstM_i == src)   v = W_valM_i;
        else if (W_dstE_i == src)   v = W_valE_i;
        else                        v = rf_val;
        return v;
    endfunction

    logic [DW-1:0] fwd_a, fwd_b, val_a;

    always_comb begin
        fwd_a = fwd(src_a, rf_a);
        fwd_b = fwd(src_b, rf_b);
        // CALL/JXX carry the return / fall-through PC down the pipe in valA
        val_a = ((D_icode_i == I_CALL) || (D_icode_i == I_JXX)) ? D_valP_i : fwd_a;
    end

    // ------------------------------------------------------------- load/use
    always_comb begin
        d_load_use_o = D_valid_i
                    && ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ))
                    && (E_dstM_i != R_NONE)
                    && ((E_dstM_i == src_a) || (E_dstM_i == src_b));
    end

    logic load_bubble;
    assign load_bubble = E_bubble_i | d_load_use_o;

    // ----------------------------------------------------------- E register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            E_valid_o <= 1'b0;
            E_icode_o <= I_NOP;
            E_valA_o  <= '0;
            E_valB_o  <= '0;
            E_valC_o  <= '0;
            E_dstE_o  <= R_NONE;
            E_dstM_o  <= R_NONE;
            E_srcA_o  <= R_NONE;
            E_srcB_o  <= R_NONE;
        end else if (E_stall_i) begin
            E_valid_o <= E_valid_o;
        end else if (load_bubble) begin
            E_valid_o <= 1'b0;
            E_icode_o <= I_NOP;
            E_valA_o  <= '0;
            E_valB_o  <= '0;
            E_valC_o  <= '0;
            E_dstE_o  <= R_NONE;
            E_dstM_o  <= R_NONE;
            E_srcA_o  <= R_NONE;
            E_srcB_o  <= R_NONE;
        end else begin
            E_valid_o <= D_valid_i;
            E_icode_o <= D_icode_i;
            E_valA_o  <= val_a;
            E_valB_o  <= fwd_b;
            E_valC_o  <= D_valC_i;
            E_dstE_o  <= dst_e;
            E_dstM_o  <= dst_m;
            E_srcA_o  <= src_a;
            E_srcB_o  <= src_b;
        end
    end

    // --------------------------------------------------- performance counters
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_reg, bubble_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (E_stall_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            // a bubble only counts when it is actually loaded, i.e. not stalled
            if (!E_stall_i && load_bubble && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o  = stall_cnt_reg;
    assign perf_bubble_cnt_o = bubble_cnt_reg;
`else
    assign perf_stall_cnt_o  = 32'h0;
    assign perf_bubble_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_decode_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_reg
//   Directed literal checks of forwarding, interlock, stall, reset and counters,
//   followed by randomized traffic compared every cycle against a behavioural
//   model of the decode stage.
// -----------------------------------------------------------------------------
module tb_decode_stage_reg;

    localparam int         NREG  = 15;
    localparam logic [4:0] NREG5 = 5'd15;
    localparam logic [3:0] F     = 4'hF;
    localparam logic [3:0] NOP = 4'h1, CMOV = 4'h2, IRMOV = 4'h3, RMMOV = 4'h4, MRMOV = 4'h5;
    localparam logic [3:0] OPQ = 4'h6, JXX = 4'h7, CALL = 4'h8, RET = 4'h9, PUSH = 4'hA, POP = 4'hB;
    localparam logic [3:0] SP  = 4'h4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        D_valid_i;
    logic [3:0]  D_icode_i, D_rA_i, D_rB_i;
    logic [63:0] D_valC_i, D_valP_i;
    logic [3:0]  e_dstE_i, M_dstM_i, M_dstE_i, W_dstM_i, W_dstE_i;
    logic [63:0] e_valE_i, m_valM_i, M_valE_i, W_valM_i, W_valE_i;
    logic [3:0]  E_icode_i, E_dstM_i;
    logic        E_stall_i, E_bubble_i;
    logic        d_load_use_o, E_valid_o;
    logic [3:0]  E_icode_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;
    logic [63:0] E_valA_o, E_valB_o, E_valC_o;
    logic [31:0] perf_stall_cnt_o, perf_bubble_cnt_o;

    always #5 clk = ~clk;

    decode_stage_reg #(.DW(64), .NREG(15), .SP_ID(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .D_valid_i(D_valid_i), .D_icode_i(D_icode_i), .D_rA_i(D_rA_i), .D_rB_i(D_rB_i),
        .D_valC_i(D_valC_i), .D_valP_i(D_valP_i),
        .e_dstE_i(e_dstE_i), .e_valE_i(e_valE_i),
        .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
        .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i),
        .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
        .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i),
        .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i),
        .E_stall_i(E_stall_i), .E_bubble_i(E_bubble_i),
        .d_load_use_o(d_load_use_o),
        .E_valid_o(E_valid_o), .E_icode_o(E_icode_o),
        .E_valA_o(E_valA_o), .E_valB_o(E_valB_o), .E_valC_o(E_valC_o),
        .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o),
        .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o),
        .perf_stall_cnt_o(perf_stall_cnt_o), .perf_bubble_cnt_o(perf_bubble_cnt_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ behavioural model
    function automatic logic [3:0] f_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {CMOV, RMMOV, OPQ, PUSH}) return ra;
        if (ic inside {POP, RET}) return SP;
        return F;
    endfunction
    function automatic logic [3:0] f_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {OPQ, RMMOV, MRMOV}) return rb;
        if (ic inside {PUSH, POP, CALL, RET}) return SP;
        return F;
    endfunction
    function automatic logic [3:0] f_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {CMOV, IRMOV, OPQ}) return rb;
        if (ic inside {PUSH, POP, CALL, RET}) return SP;
        return F;
    endfunction
    function automatic logic [3:0] f_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {MRMOV, POP}) return ra;
        return F;
    endfunction

    logic [63:0] m_regs [NREG];
    logic        m_valid;
    logic [3:0]  m_icode, m_dstE, m_dstM, m_srcA, m_srcB;
    logic [63:0] m_valA, m_valB, m_valC;
    logic [31:0] m_stall_cnt, m_bubble_cnt;

    // value an operand must take: scan producers youngest first, then the file
    function automatic logic [63:0] f_read(input logic [3:0] src);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        if (src == F) return 64'h0;
        d[0] = e_dstE_i; v[0] = e_valE_i;
        d[1] = M_dstM_i; v[1] = m_valM_i;
        d[2] = M_dstE_i; v[2] = M_valE_i;
        d[3] = W_dstM_i; v[3] = W_valM_i;
        d[4] = W_dstE_i; v[4] = W_valE_i;
        for (int k = 0; k < 5; k++) if (d[k] == src) return v[k];
        if ({1'b0, src} < NREG5) return m_regs[src];
        return 64'h0;
    endfunction

    function automatic logic f_lu();
        logic [3:0] a, b;
        a = f_srcA(D_icode_i, D_rA_i);
        b = f_srcB(D_icode_i, D_rB_i);
        return D_valid_i && (E_icode_i inside {MRMOV, POP}) && (E_dstM_i != F)
               && (E_dstM_i == a || E_dstM_i == b);
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_valid <= 1'b0; m_icode <= NOP;
            m_valA <= 64'h0; m_valB <= 64'h0; m_valC <= 64'h0;
            m_dstE <= F; m_dstM <= F; m_srcA <= F; m_srcB <= F;
            m_stall_cnt <= 32'h0; m_bubble_cnt <= 32'h0;
            for (int i = 0; i < NREG; i++) m_regs[i] <= 64'h0;
        end else begin
            if (E_stall_i) begin
                if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 1;
            end else if (E_bubble_i || f_lu()) begin
                m_valid <= 1'b0; m_icode <= NOP;
                m_valA <= 64'h0; m_valB <= 64'h0; m_valC <= 64'h0;
                m_dstE <= F; m_dstM <= F; m_srcA <= F; m_srcB <= F;
                if (m_bubble_cnt != 32'hFFFF_FFFF) m_bubble_cnt <= m_bubble_cnt + 1;
            end else begin
                m_valid <= D_valid_i;
                m_icode <= D_icode_i;
                m_valA  <= (D_icode_i inside {CALL, JXX}) ? D_valP_i
                                                         : f_read(f_srcA(D_icode_i, D_rA_i));
                m_valB  <= f_read(f_srcB(D_icode_i, D_rB_i));
                m_valC  <= D_valC_i;
                m_dstE  <= f_dstE(D_icode_i, D_rB_i);
                m_dstM  <= f_dstM(D_icode_i, D_rA_i);
                m_srcA  <= f_srcA(D_icode_i, D_rA_i);
                m_srcB  <= f_srcB(D_icode_i, D_rB_i);
            end
            if ({1'b0, W_dstE_i} < NREG5) m_regs[W_dstE_i] <= W_valE_i;
            // later NBA wins: valM overrides valE for the same register
            if ({1'b0, W_dstM_i} < NREG5) m_regs[W_dstM_i] <= W_valM_i;
        end
    end

    // ------------------------------------------------------- compare process
    always @(negedge clk) begin
        if (!rst_i) begin
            chk("lu",    d_load_use_o, f_lu());
            chk("valid", E_valid_o, m_valid);
            chk("icode", E_icode_o, m_icode);
            chk("valA",  E_valA_o,  m_valA);
            chk("valB",  E_valB_o,  m_valB);
            chk("valC",  E_valC_o,  m_valC);
            chk("dstE",  E_dstE_o,  m_dstE);
            chk("dstM",  E_dstM_o,  m_dstM);
            chk("srcA",  E_srcA_o,  m_srcA);
            chk("srcB",  E_srcB_o,  m_srcB);
`ifdef DECODE_PERF_CNT_EN
            chk("stall_cnt",  perf_stall_cnt_o,  m_stall_cnt);
            chk("bubble_cnt", perf_bubble_cnt_o, m_bubble_cnt);
`else
            chk("stall_cnt",  perf_stall_cnt_o,  32'h0);
            chk("bubble_cnt", perf_bubble_cnt_o, 32'h0);
`endif
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic idle();
        D_valid_i = 1'b0; D_icode_i = NOP; D_rA_i = F; D_rB_i = F;
        D_valC_i = 64'h0; D_valP_i = 64'h0;
        e_dstE_i = F; M_dstM_i = F; M_dstE_i = F; W_dstM_i = F; W_dstE_i = F;
        e_valE_i = 64'h0; m_valM_i = 64'h0; M_valE_i = 64'h0; W_valM_i = 64'h0; W_valE_i = 64'h0;
        E_icode_i = NOP; E_dstM_i = F; E_stall_i = 1'b0; E_bubble_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rid();
        if ($urandom_range(0, 3) == 0) return F;
        return 4'($urandom_range(0, 5));
    endfunction

    function automatic logic [63:0] rval();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_valid", E_valid_o, 1'b0);
        chk("rst_icode", E_icode_o, NOP);
        chk("rst_dstE",  E_dstE_o, F);
        chk("rst_valA",  E_valA_o, 64'h0);
        chk("rst_cnt",   perf_bubble_cnt_o, 32'h0);
        rst_i = 1'b0;

        // 1: simultaneous writebacks to one register, valM wins
        W_dstE_i = 4'd3; W_valE_i = 64'hAA; W_dstM_i = 4'd3; W_valM_i = 64'hBB;
        tick();
        idle();
        D_valid_i = 1'b1; D_icode_i = OPQ; D_rA_i = 4'd3; D_rB_i = F;
        tick();
        chk("t1_valA", E_valA_o, 64'hBB);
        chk("t1_dstE", E_dstE_o, F);

        // 2: forwarding priority
        idle();
        D_valid_i = 1'b1; D_icode_i = OPQ; D_rA_i = 4'd2; D_rB_i = F;
        e_dstE_i = 4'd2; e_valE_i = 64'h11;
        M_dstE_i = 4'd2; M_valE_i = 64'h22;
        W_dstE_i = 4'd2; W_valE_i = 64'h33;
        tick(); chk("t2_e", E_valA_o, 64'h11);
        e_dstE_i = F;
        tick(); chk("t2_M", E_valA_o, 64'h22);
        M_dstE_i = F;
        tick(); chk("t2_W", E_valA_o, 64'h33);
        W_dstE_i = F;
        tick(); chk("t2_rf", E_valA_o, 64'h33);   // written by W on the earlier edges

        // 3: load/use interlock
        idle();
        E_icode_i = MRMOV; E_dstM_i = 4'd5;
        D_valid_i = 1'b1; D_icode_i = OPQ; D_rA_i = 4'd1; D_rB_i = 4'd5;
        #1 chk("t3_lu", d_load_use_o, 1'b1);
        tick();
        chk("t3_valid", E_valid_o, 1'b0);
        chk("t3_icode", E_icode_o, NOP);
        chk("t3_dstE",  E_dstE_o, F);
        E_dstM_i = F;
        #1 chk("t3_nolu", d_load_use_o, 1'b0);
        tick();
        chk("t3_valid2", E_valid_o, 1'b1);
        chk("t3_dstE2",  E_dstE_o, 4'd5);

        // 4: stall beats the load/use bubble; CALL carries valP
        E_dstM_i = 4'd5; E_stall_i = 1'b1;
        tick();
        chk("t4_hold_valid", E_valid_o, 1'b1);
        chk("t4_hold_icode", E_icode_o, OPQ);
        chk("t4_hold_dstE",  E_dstE_o, 4'd5);
        idle();
        D_valid_i = 1'b1; D_icode_i = CALL; D_valP_i = 64'h40;
        W_dstE_i = 4'd7; W_valE_i = 64'h1234;
        tick();
        chk("t4_valA", E_valA_o, 64'h40);
        chk("t4_srcB", E_srcB_o, 4'd4);
        chk("t4_dstE", E_dstE_o, 4'd4);

        // 5: asynchronous reset mid-cycle
        idle();
        #1 rst_i = 1'b1;
        #1;
        chk("t5_valid", E_valid_o, 1'b0);
        chk("t5_icode", E_icode_o, NOP);
        chk("t5_valA",  E_valA_o, 64'h0);
        chk("t5_srcB",  E_srcB_o, F);
        rst_i = 1'b0;
        D_valid_i = 1'b1; D_icode_i = OPQ; D_rA_i = 4'd7; D_rB_i = 4'd3;
        tick();
        chk("t5_rd7", E_valA_o, 64'h0);
        chk("t5_rd3", E_valB_o, 64'h0);

        // 6: counters: 3 load/use bubbles, then 2 stalls
        E_icode_i = POP; E_dstM_i = 4'd7;
        repeat (3) tick();
        E_dstM_i = F; E_stall_i = 1'b1;
        repeat (2) tick();
        E_stall_i = 1'b0;
`ifdef DECODE_PERF_CNT_EN
        chk("t6_bubble", perf_bubble_cnt_o, 32'd3);
        chk("t6_stall",  perf_stall_cnt_o,  32'd2);
`else
        chk("t6_bubble", perf_bubble_cnt_o, 32'd0);
        chk("t6_stall",  perf_stall_cnt_o,  32'd0);
`endif

        // randomized traffic, checked by the compare process
        for (int n = 0; n < 600; n++) begin
            D_valid_i  = ($urandom_range(0, 7) != 0);
            D_icode_i  = 4'($urandom_range(0, 11));
            D_rA_i     = rid();
            D_rB_i     = rid();
            D_valC_i   = rval();
            D_valP_i   = rval();
            e_dstE_i   = rid(); e_valE_i = rval();
            M_dstM_i   = rid(); m_valM_i = rval();
            M_dstE_i   = rid(); M_valE_i = rval();
            W_dstM_i   = rid(); W_valM_i = rval();
            W_dstE_i   = rid(); W_valE_i = rval();
            case ($urandom_range(0, 3))
                0:       E_icode_i = MRMOV;
                1:       E_icode_i = POP;
                2:       E_icode_i = OPQ;
                default: E_icode_i = NOP;
            endcase
            E_dstM_i   = rid();
            E_stall_i  = ($urandom_range(0, 7) == 0);
            E_bubble_i = ($urandom_range(0, 7) == 0);
            tick();
        end

        idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
